// File: rtl/cart_mem_sched.sv
// Cartridge memory scheduler: serialises mapped PRG and CHR accesses
// onto one single-port cart memory. CHR has priority; PRG wait is bounded.
module cart_mem_sched #(
    parameter int AW           = 22,
    parameter int PRG_MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prg_read,
    input  logic          prg_write,
    input  logic [AW-1:0] prg_aout,
    input  logic          prg_allow,
    input  logic [7:0]    prg_din,
    output logic [7:0]    prg_dout,
    output logic          prg_done,
    input  logic          chr_read,
    input  logic          chr_write,
    input  logic [AW-1:0] chr_aout,
    input  logic          chr_allow,
    input  logic          vram_ce,
    input  logic [7:0]    chr_din,
    output logic [7:0]    chr_dout,
    output logic          chr_done,
    output logic [1:0]    overrun,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic          mem_ack,
    input  logic [7:0]    mem_rdata
);
    localparam int WW = (PRG_MAX_WAIT < 1) ? 1 : $clog2(PRG_MAX_WAIT + 1);
    localparam logic [WW-1:0] W_MAX = WW'(PRG_MAX_WAIT);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_t;

    logic [3:0]    r_stb_q;
    logic [3:0]    r_stb_qq;
    logic          r_prg_pend;
    logic          r_prg_we;
    logic [AW-1:0] r_prg_addr;
    logic [7:0]    r_prg_wd;
    logic          r_chr_pend;
    logic          r_chr_we;
    logic [AW-1:0] r_chr_addr;
    logic [7:0]    r_chr_wd;
    state_t        r_state;
    logic          r_sel_chr;
    logic [WW-1:0] r_prg_wait;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [7:0]    r_mem_wdata;
    logic [7:0]    r_prg_dout;
    logic [7:0]    r_chr_dout;
    logic          r_prg_done;
    logic          r_chr_done;
    logic [1:0]    r_overrun;

    logic [3:0] w_rise;
    logic       w_ack;
    logic       w_prg_free;
    logic       w_chr_free;
    logic       w_prg_ok;
    logic       w_chr_ok;
    logic       w_force;
    logic       w_pick_chr;

    // Bit order {chr_write, chr_read, prg_write, prg_read}
    assign w_rise     = r_stb_q & ~r_stb_qq;
    assign w_ack      = (r_state == S_BUSY) & mem_ack;
    // A slot releasing on ack this cycle can take a new request
    assign w_prg_free = ~r_prg_pend | (w_ack & ~r_sel_chr);
    assign w_chr_free = ~r_chr_pend | (w_ack & r_sel_chr);
    assign w_prg_ok   = (w_rise[0] | w_rise[1]) & prg_allow;
    assign w_chr_ok   = (w_rise[2] | w_rise[3]) & ~vram_ce
                      & (~w_rise[3] | chr_allow);
    assign w_force    = (r_prg_wait >= W_MAX);
    assign w_pick_chr = r_chr_pend & ~(r_prg_pend & w_force);

    assign prg_dout  = r_prg_dout;
    assign prg_done  = r_prg_done;
    assign chr_dout  = r_chr_dout;
    assign chr_done  = r_chr_done;
    assign overrun   = r_overrun;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // Two-stage strobe registers for rising-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stb_q  <= '0;
            r_stb_qq <= '0;
        end else begin
            r_stb_q  <= {chr_write, chr_read, prg_write, prg_read};
            r_stb_qq <= r_stb_q;
        end
    end

    // PRG slot: capture on an allowed edge when free, release on its ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prg_pend <= 1'b0;
            r_prg_we   <= 1'b0;
            r_prg_addr <= '0;
            r_prg_wd   <= '0;
        end else begin
            if (w_ack && !r_sel_chr) r_prg_pend <= 1'b0;
            if (w_prg_ok && w_prg_free) begin
                r_prg_pend <= 1'b1;
                r_prg_we   <= w_rise[1];
                r_prg_addr <= prg_aout;
                r_prg_wd   <= prg_din;
            end
        end
    end

    // CHR slot: capture on a cart-routed, permitted edge when free
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chr_pend <= 1'b0;
            r_chr_we   <= 1'b0;
            r_chr_addr <= '0;
            r_chr_wd   <= '0;
        end else begin
            if (w_ack && r_sel_chr) r_chr_pend <= 1'b0;
            if (w_chr_ok && w_chr_free) begin
                r_chr_pend <= 1'b1;
                r_chr_we   <= w_rise[3];
                r_chr_addr <= chr_aout;
                r_chr_wd   <= chr_din;
            end
        end
    end

    // One-cycle overrun flag for accepted-class edges hitting a busy slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun <= 2'b00;
        end else begin
            r_overrun <= {w_chr_ok & ~w_chr_free, w_prg_ok & ~w_prg_free};
        end
    end

    // Arbiter and memory handshake FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sel_chr   <= 1'b0;
            r_prg_wait  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_prg_dout  <= '0;
            r_chr_dout  <= '0;
            r_prg_done  <= 1'b0;
            r_chr_done  <= 1'b0;
        end else begin
            r_prg_done <= 1'b0;
            r_chr_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (r_prg_pend || r_chr_pend) begin
                        r_state     <= S_BUSY;
                        r_sel_chr   <= w_pick_chr;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_pick_chr ? r_chr_we : r_prg_we;
                        r_mem_addr  <= w_pick_chr ? r_chr_addr : r_prg_addr;
                        r_mem_wdata <= w_pick_chr ? r_chr_wd : r_prg_wd;
                        if (!w_pick_chr) begin
                            r_prg_wait <= '0;
                        end else if (r_prg_pend && r_prg_wait < W_MAX) begin
                            r_prg_wait <= r_prg_wait + 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= S_GAP;
                        if (r_sel_chr) begin
                            r_chr_done <= 1'b1;
                            if (!r_mem_we) r_chr_dout <= mem_rdata;
                        end else begin
                            r_prg_done <= 1'b1;
                            if (!r_mem_we) r_prg_dout <= mem_rdata;
                        end
                    end
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cart_mem_sched.sv
// Directed bench for cart_mem_sched with an auto-acking memory model.
// Memory read data is addr[7:0] ^ 0x86.
module tb_cart_mem_sched;
    localparam int AW = 22;

    logic          clk = 1'b0;
    logic          reset;
    logic          prg_read, prg_write, prg_allow;
    logic [AW-1:0] prg_aout;
    logic [7:0]    prg_din, prg_dout;
    logic          prg_done;
    logic          chr_read, chr_write, chr_allow, vram_ce;
    logic [AW-1:0] chr_aout;
    logic [7:0]    chr_din, chr_dout;
    logic          chr_done;
    logic [1:0]    overrun;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_ack;
    logic [7:0]    mem_rdata;

    logic auto_ack = 1'b0;
    logic man_ack  = 1'b0;
    int   ack_lat  = 1;
    int   req_cnt  = 0;

    int checks = 0;
    int errors = 0;

    int n_req = 0, n_pd = 0, n_cd = 0, n_op = 0, n_oc = 0;
    int low_run = 0, gap_last = 0;
    logic prev_req = 1'b0;

    logic [AW-1:0] log_addr[$];
    logic          log_we[$];
    logic [7:0]    log_wd[$];

    assign mem_ack = auto_ack | man_ack;

    always #5 clk = ~clk;

    cart_mem_sched #(.AW(AW), .PRG_MAX_WAIT(2)) dut (
        .clk(clk), .reset(reset),
        .prg_read(prg_read), .prg_write(prg_write), .prg_aout(prg_aout),
        .prg_allow(prg_allow), .prg_din(prg_din), .prg_dout(prg_dout),
        .prg_done(prg_done),
        .chr_read(chr_read), .chr_write(chr_write), .chr_aout(chr_aout),
        .chr_allow(chr_allow), .vram_ce(vram_ce), .chr_din(chr_din),
        .chr_dout(chr_dout), .chr_done(chr_done),
        .overrun(overrun),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Memory model: ack in the ack_lat-th request cycle, log the access
    always @(negedge clk) begin
        if (auto_ack) begin
            auto_ack = 1'b0;
            req_cnt  = 0;
        end else if (mem_req) begin
            req_cnt++;
            if (req_cnt == ack_lat) begin
                auto_ack  = 1'b1;
                mem_rdata = mem_addr[7:0] ^ 8'h86;
                log_addr.push_back(mem_addr);
                log_we.push_back(mem_we);
                log_wd.push_back(mem_wdata);
            end
        end else begin
            req_cnt = 0;
        end
    end

    // Event counters and mem_req low-run measurement
    always @(negedge clk) begin
        n_req += int'(mem_req);
        n_pd  += int'(prg_done);
        n_cd  += int'(chr_done);
        n_op  += int'(overrun[0]);
        n_oc  += int'(overrun[1]);
        if (mem_req) begin
            if (!prev_req) gap_last = low_run;
            low_run = 0;
        end else begin
            low_run++;
        end
        prev_req = mem_req;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic starve_round(input string tag);
        int L;
        L = log_addr.size();
        prg_aout = 22'h000111;
        chr_aout = 22'h000222;
        ack_lat  = 1;
        prg_read = 1'b1;
        chr_read = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chr_read = mem_req;
        end
        chr_read = 1'b0;
        prg_read = 1'b0;
        repeat (15) @(negedge clk);
        chk({tag, "_n"}, 32'(log_addr.size() >= L + 3), 1);
        chk({tag, "_a0"}, 32'(log_addr[L]), 32'h222);
        chk({tag, "_a1"}, 32'(log_addr[L + 1]), 32'h222);
        chk({tag, "_a2"}, 32'(log_addr[L + 2]), 32'h111);
    endtask

    initial begin
        int s_req, s_pd, s_cd, s_op, s_oc, L;
        reset = 1'b1;
        prg_read = 0; prg_write = 0; prg_allow = 0;
        prg_aout = '0; prg_din = '0;
        chr_read = 0; chr_write = 0; chr_allow = 0; vram_ce = 0;
        chr_aout = '0; chr_din = '0;
        mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_pdout", 32'(prg_dout), 0);
        chk("rst_cdout", 32'(chr_dout), 0);
        chk("rst_done", 32'({prg_done, chr_done, overrun}), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // PRG read, ack in 3rd request cycle
        ack_lat = 3;
        prg_aout = 22'h000123;
        prg_allow = 1'b1;
        prg_read = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            case (c)
                1: chk("t1_c1_req", 32'(mem_req), 0);
                2: chk("t1_c2_req", 32'(mem_req), 1);
                4: begin
                    chk("t1_c4_req", 32'(mem_req), 1);
                    chk("t1_c4_addr", 32'(mem_addr), 32'h123);
                    chk("t1_c4_we", 32'(mem_we), 0);
                end
                5: begin
                    chk("t1_c5_req", 32'(mem_req), 0);
                    chk("t1_c5_done", 32'(prg_done), 1);
                    chk("t1_c5_dout", 32'(prg_dout), 32'hA5);
                end
                6: chk("t1_c6_done", 32'(prg_done), 0);
                default: ;
            endcase
        end
        prg_read = 1'b0;
        repeat (3) @(negedge clk);

        // Disallowed accesses
        s_req = n_req; s_pd = n_pd; s_cd = n_cd; s_op = n_op; s_oc = n_oc;
        prg_allow = 1'b0;
        prg_din = 8'h11;
        prg_write = 1'b1;
        repeat (2) @(negedge clk);
        prg_write = 1'b0;
        chr_allow = 1'b0;
        chr_write = 1'b1;
        repeat (2) @(negedge clk);
        chr_write = 1'b0;
        vram_ce = 1'b1;
        chr_read = 1'b1;
        repeat (2) @(negedge clk);
        chr_read = 1'b0;
        repeat (6) @(negedge clk);
        vram_ce = 1'b0;
        chk("t2_req", 32'(n_req - s_req), 0);
        chk("t2_done", 32'((n_pd - s_pd) + (n_cd - s_cd)), 0);
        chk("t2_ovr", 32'((n_op - s_op) + (n_oc - s_oc)), 0);
        chk("t2_pdout", 32'(prg_dout), 32'hA5);
        chk("t2_cdout", 32'(chr_dout), 0);

        // Permitted CHR write
        L = log_addr.size();
        s_cd = n_cd;
        ack_lat = 1;
        chr_allow = 1'b1;
        chr_aout = 22'h000010;
        chr_din = 8'h3C;
        chr_write = 1'b1;
        repeat (8) @(negedge clk);
        chr_write = 1'b0;
        chk("t2w_n", 32'(log_addr.size() - L), 1);
        chk("t2w_we", 32'(log_we[L]), 1);
        chk("t2w_addr", 32'(log_addr[L]), 32'h10);
        chk("t2w_wd", 32'(log_wd[L]), 32'h3C);
        chk("t2w_done", 32'(n_cd - s_cd), 1);
        chk("t2w_cdout", 32'(chr_dout), 0);

        // Simultaneous capture: CHR first, then PRG
        L = log_addr.size();
        s_pd = n_pd; s_cd = n_cd;
        ack_lat = 2;
        prg_allow = 1'b1;
        prg_aout = 22'h000200;
        chr_aout = 22'h000345;
        prg_read = 1'b1;
        chr_read = 1'b1;
        repeat (3) @(negedge clk);
        prg_read = 1'b0;
        chr_read = 1'b0;
        repeat (15) @(negedge clk);
        chk("t3_n", 32'(log_addr.size() - L), 2);
        chk("t3_first", 32'(log_addr[L]), 32'h345);
        chk("t3_second", 32'(log_addr[L + 1]), 32'h200);
        chk("t3_gap", 32'(gap_last), 2);
        chk("t3_pdone", 32'(n_pd - s_pd), 1);
        chk("t3_cdone", 32'(n_cd - s_cd), 1);
        chk("t3_pdout", 32'(prg_dout), 32'h86);
        chk("t3_cdout", 32'(chr_dout), 32'hC3);

        // Starvation guard, twice to show the wait count restarts
        starve_round("t4a");
        starve_round("t4b");

        // Overrun: second PRG edge while the first is in flight
        L = log_addr.size();
        s_pd = n_pd; s_op = n_op;
        ack_lat = 4;
        prg_aout = 22'h000050;
        prg_read = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            case (c)
                1: prg_read = 1'b0;
                2: prg_read = 1'b1;
                3: chk("t5_c3_ovr", 32'(overrun), 0);
                4: chk("t5_c4_ovr", 32'(overrun), 32'h1);
                5: chk("t5_c5_ovr", 32'(overrun), 0);
                default: ;
            endcase
        end
        prg_read = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_n", 32'(log_addr.size() - L), 1);
        chk("t5_pdone", 32'(n_pd - s_pd), 1);
        chk("t5_novr", 32'(n_op - s_op), 1);

        // Edge in the ack cycle is accepted
        L = log_addr.size();
        s_pd = n_pd; s_op = n_op;
        prg_read = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            case (c)
                1: prg_read = 1'b0;
                4: prg_read = 1'b1;
                6: chk("t5b_c6_ovr", 32'(overrun), 0);
                default: ;
            endcase
        end
        prg_read = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5b_n", 32'(log_addr.size() - L), 2);
        chk("t5b_pdone", 32'(n_pd - s_pd), 2);
        chk("t5b_novr", 32'(n_op - s_op), 0);
        chk("t5b_pdout", 32'(prg_dout), 32'hD6);

        // Reset during BUSY, then a late ack
        ack_lat = 100;
        prg_aout = 22'h000077;
        prg_read = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_busy", 32'(mem_req), 1);
        prg_read = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("t6_async", 32'(mem_req), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        s_req = n_req; s_pd = n_pd; s_cd = n_cd;
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_req", 32'(n_req - s_req), 0);
        chk("t6_done", 32'((n_pd - s_pd) + (n_cd - s_cd)), 0);
        chk("t6_pdout", 32'(prg_dout), 0);
        chk("t6_cdout", 32'(chr_dout), 0);

        // Recovery after reset
        ack_lat = 1;
        prg_aout = 22'h000123;
        prg_read = 1'b1;
        repeat (10) @(negedge clk);
        prg_read = 1'b0;
        chk("t6_recover", 32'(prg_dout), 32'hA5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
